wb_arbiter_n: RTL
=================

# wb_arbiter_n

Parametrised N-master to 1-slave Wishbone classic arbiter for the shared external memory port (cellram) on the SoC bus. It extends the two-master fixed-priority arbiter with a configurable master count, a selectable fixed-priority or round-robin policy, abandoned-cycle release, per-master error reporting on timeout, and a configurable post-reset strobe hold-off. It sits between the bus masters (video cache, CPU, DMA, ...) and the cellram Wishbone controller.

## Interface
- NUM_M, 2: number of masters, 2..8; index 0 = highest fixed priority.
- AW, 32: address width.
- DW, 32: data width; SEL width = DW/8.
- RR, 0: 0 = fixed priority, 1 = round-robin.
- TO_BITS, 10: timeout counter width; timeout fires when the counter is all-ones.
- HOLD_CYC, 15: cycles after reset during which slave stb is forced low, 0..255.

Ports:
- wb_clk  in  1  bus clock; all state updates on the rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- m_adr_i  in  NUM_M*AW  master addresses; master i at [i*AW +: AW].
- m_dat_i  in  NUM_M*DW  master write data, packed as above.
- m_sel_i  in  NUM_M*DW/8  master byte selects.
- m_cyc_i, m_stb_i, m_we_i  in  NUM_M  per-master cycle, strobe and write-enable bits.
- m_dat_o  out  DW  read data, a copy of s_dat_i broadcast to all masters.
- m_ack_o  out  NUM_M  per-master acknowledge.
- m_err_o  out  NUM_M  per-master timeout error.
- m_gnt_o  out  NUM_M  one-hot grant; all zero when idle.
- s_adr_o, s_dat_o, s_sel_o  out  AW, DW, DW/8  slave address, write data, byte selects.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.

## Operation
- Request from master i: m_cyc_i[i] & m_stb_i[i].
- FSM has two states, IDLE and BUSY. Registered state: owner index gidx, last-served index lidx, timeout counter tcnt, hold counter hcnt.
- IDLE, at least one request: choose the winner, set gidx to the winner, go to BUSY.
  - RR=0: winner is the lowest requesting index.
  - RR=1: winner is the first requesting index after lidx, wrapping modulo NUM_M.
- IDLE, no request: stay in IDLE.
- BUSY → IDLE on any of:
  - s_ack_i;
  - timeout (tcnt all-ones);
  - owner deasserts m_cyc_i (abandoned cycle).
- On every BUSY → IDLE transition: lidx <= gidx, tcnt <= 0.
- Muxing: s_adr_o, s_dat_o, s_sel_o and s_we_o always follow master gidx. gidx holds its last value while IDLE.
- Slave control:
  - s_cyc_o = BUSY & m_cyc_i[gidx].
  - s_stb_o = BUSY & m_stb_i[gidx] & (hcnt==0).
- Master responses:
  - m_ack_o[gidx] = BUSY & s_ack_i; all other ack bits are 0.
  - m_err_o[gidx] = BUSY & (tcnt all-ones) & !s_ack_i.
  - m_gnt_o = one-hot of gidx when BUSY, else 0.
- Timeout counter: cleared on s_ack_i; otherwise increments on each cycle with s_cyc_o & s_stb_o. It therefore does not advance during the hold-off period.
- Hold counter: loaded with HOLD_CYC at reset, decrements to 0, then stays at 0.

## Timing
- Reset values:
  - State IDLE, gidx=0, tcnt=0, hcnt=HOLD_CYC.
  - lidx=NUM_M-1, so master 0 wins first under RR.
  - All m_gnt_o, m_ack_o, m_err_o, s_cyc_o and s_stb_o are 0.
- Grant latency: a request seen at edge n gives gnt, s_cyc_o and s_stb_o high after edge n.
- ack/err path: combinational, slave to master, same cycle.
- Release: grant drops at the edge after ack, err or abandon. At least one IDLE cycle separates grants, so a back-to-back single master gets one access every ≥3 cycles with a 1-cycle slave.
- Simultaneous events:
  - s_ack_i together with timeout: ack wins, no err.
  - s_ack_i together with cyc drop: treated as a normal ack.
  - New requests while BUSY are ignored until IDLE.
- Reset in mid-transfer: state goes to IDLE at that edge, and s_cyc_o/s_stb_o are low in the following cycle.
- A spurious s_ack_i while IDLE is not forwarded to any master.

## Test plan
- Fixed priority (RR=0, NUM_M=3): masters 0 and 2 request in the same cycle; slave acks 1 cycle after stb → m_gnt_o=3'b001 first. After ack, one IDLE cycle, then 3'b100. s_adr_o matches the granted master's address each time.
- Round-robin (RR=1, NUM_M=4): all masters request continuously → grant order 0,1,2,3,0. m_ack_o is one-hot and matches m_gnt_o.
- Timeout (TO_BITS=4): slave never acks → m_err_o[owner] pulses for 1 cycle after 15 strobed cycles, grant drops at the next edge, tcnt=0.
- Ack on the timeout cycle: s_ack_i asserted exactly when tcnt=all-ones → m_ack_o=1, m_err_o=0.
- Hold-off (HOLD_CYC=15): request from master 0 immediately after reset → m_gnt_o=1 and s_cyc_o=1 but s_stb_o=0 until hcnt reaches 0; the first s_stb_o appears no earlier than the 16th cycle after reset.
- Abandon and mid-reset:
  - Owner drops cyc with no ack → IDLE next cycle, no ack or err.
  - wb_rst asserted while BUSY → all outputs 0 after the edge.

Source files
------------

// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-master to 1-slave Wishbone classic arbiter for the shared
// cellram port. Fixed-priority or round-robin selection, release on ack,
// timeout or abandoned cycle, per-master timeout error and a post-reset
// strobe hold-off.
module wb_arbiter_n #(
  parameter int NUM_M    = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RR       = 0,
  parameter int TO_BITS  = 10,
  parameter int HOLD_CYC = 15
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_gnt_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic [IW-1:0]        gidx_q;
  logic [IW-1:0]        lidx_q;
  logic [TO_BITS-1:0]   tcnt_q;
  logic [7:0]           hcnt_q;

  logic [NUM_M-1:0]     req;
  logic [IW-1:0]        gidx_d;
  logic [NUM_M-1:0]     own_oh;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 busy;
  logic                 to_hit;
  logic                 hold_done;

  // Lowest requesting index wins.
  function automatic logic [IW-1:0] pick_fixed(input logic [NUM_M-1:0] r);
    logic [IW-1:0] w;
    w = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (r[i +: 1] == 1'b1) w = IW'(i);
    end
    return w;
  endfunction

  // First requesting index after the last served one, wrapping at NUM_M.
  function automatic logic [IW-1:0] pick_rr(input logic [NUM_M-1:0] r,
                                            input logic [IW-1:0] last);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!found && (r[idx +: 1] == 1'b1)) begin
        w     = IW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign req       = m_cyc_i & m_stb_i;
  assign busy      = (state_q == BUSY);
  assign to_hit    = &tcnt_q;
  assign hold_done = (hcnt_q == 8'd0);
  assign gidx_d    = (RR != 0) ? pick_rr(req, lidx_q) : pick_fixed(req);

  // Route the owner's request fields to the slave and build its one-hot mask.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_oh  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gidx_q == IW'(i)) begin
        s_adr_o        = m_adr_i[i*AW +: AW];
        s_dat_o        = m_dat_i[i*DW +: DW];
        s_sel_o        = m_sel_i[i*SW +: SW];
        s_we_o         = m_we_i[i];
        own_cyc        = m_cyc_i[i];
        own_stb        = m_stb_i[i];
        own_oh[i]      = 1'b1;
      end
    end
  end

  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & own_stb & hold_done;
  assign m_dat_o = s_dat_i;
  assign m_gnt_o = busy ? own_oh : '0;
  assign m_ack_o = (busy & s_ack_i) ? own_oh : '0;
  assign m_err_o = (busy & to_hit & ~s_ack_i) ? own_oh : '0;

  // Arbitration FSM with owner, last-served, timeout and hold-off counters.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      lidx_q  <= IW'(NUM_M - 1);
      tcnt_q  <= '0;
      hcnt_q  <= 8'(HOLD_CYC);
    end else begin
      if (!hold_done) hcnt_q <= hcnt_q - 8'd1;
      if (state_q == IDLE) begin
        if (|req) begin
          gidx_q  <= gidx_d;
          state_q <= BUSY;
        end
        if (s_ack_i) tcnt_q <= '0;
      end else begin
        if (s_ack_i || to_hit || !own_cyc) begin
          state_q <= IDLE;
          lidx_q  <= gidx_q;
          tcnt_q  <= '0;
        end else if (s_cyc_o && s_stb_o) begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end
  end

endmodule
